// File: rtl/scratch_mem_pkg.sv
// Shared constants and clear-engine state encoding for the scratchpad RAM.
// The default geometry matches the CPU data-memory map.
package scratch_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/scratch_mem_clr_fsm.sv
// Clear engine: walks a pointer over all DEPTH words, producing a zero-write strobe
// and address, and reports busy while it owns the array.
module scratch_mem_clr_fsm
  import scratch_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // One extra pointer bit lets DEPTH == 2**ADDR_W finish without wrapping.
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  clr_state_t      state_reg, state_next;
  logic [ADDR_W:0] ptr_reg, ptr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clr) begin
          state_next = ST_CLEAR;
          ptr_next   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_next = ptr_reg + PTR_ONE;
        if (ptr_reg == LAST_PTR) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy     = (state_reg == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_reg[ADDR_W-1:0];

endmodule

// File: rtl/scratch_mem.sv
// Single-clock scratchpad RAM: separate write/read ports, registered read data with
// a valid strobe, and a hardware clear engine that locks out external access.
module scratch_mem
  import scratch_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              clr,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              port_open, wr_ok, rd_ok, rd_in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rdata_reg;
  logic              rvalid_reg;

  scratch_mem_clr_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A clr request in IDLE already claims the port, so same-cycle rd/wr are dropped.
  assign port_open   = !busy && !clr;
  assign wr_ok       = port_open && wr && ({1'b0, waddr} < DEPTH_L);
  assign rd_ok       = port_open && rd;
  assign rd_in_range = ({1'b0, raddr} < DEPTH_L);

  assign mem_we    = clr_we || wr_ok;
  assign mem_waddr = clr_we ? clr_addr : waddr;
  assign mem_wdata = clr_we ? '0 : wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= rd_ok;
      if (rd_ok) begin
        if (!rd_in_range)
          rdata_reg <= '0;
        else if (wr_ok && (waddr == raddr))
          rdata_reg <= wdata;
        else
          rdata_reg <= mem[raddr];
      end
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;

endmodule

// File: tb/tb_scratch_mem.sv
// Randomized and directed bench for scratch_mem: a DEPTH=32 and a DEPTH=20 instance
// share stimulus and are each checked against a word-array reference model.
module tb_scratch_mem;

  logic        clk = 1'b0;
  logic        rst_n, wr, rd, clr;
  logic [4:0]  waddr, raddr;
  logic [15:0] wdata;
  logic [15:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, busy_a, busy_b;

  scratch_mem #(.DATA_W(16), .ADDR_W(5), .DEPTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .waddr(waddr), .wdata(wdata),
    .rd(rd), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a),
    .clr(clr), .busy(busy_a)
  );

  scratch_mem #(.DATA_W(16), .ADDR_W(5), .DEPTH(20)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .wr(wr), .waddr(waddr), .wdata(wdata),
    .rd(rd), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b),
    .clr(clr), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model, one slot per instance: words, known flags, remaining clear cycles.
  int          dep [2] = '{32, 20};
  logic [15:0] mm  [2][32];
  bit          kn  [2][32];
  int          clr_left [2];
  bit          ev [2];
  logic [15:0] er [2];
  bit          ek [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      clr_left[k] = 0;
      ev[k] = 1'b0;
      er[k] = '0;
      ek[k] = 1'b1;
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      if (clr_left[k] > 0) begin
        mm[k][dep[k] - clr_left[k]] = '0;
        kn[k][dep[k] - clr_left[k]] = 1'b1;
        clr_left[k]--;
        ev[k] = 1'b0;
      end else if (clr) begin
        clr_left[k] = dep[k];
        ev[k] = 1'b0;
      end else begin
        if (wr && (int'(waddr) < dep[k])) begin
          mm[k][waddr] = wdata;
          kn[k][waddr] = 1'b1;
        end
        ev[k] = rd;
        if (rd) begin
          if (int'(raddr) < dep[k]) begin
            er[k] = mm[k][raddr];
            ek[k] = kn[k][raddr];
          end else begin
            er[k] = '0;
            ek[k] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "/busy32"},   32'(busy_a),   32'(clr_left[0] > 0));
    check({tag, "/busy20"},   32'(busy_b),   32'(clr_left[1] > 0));
    check({tag, "/rvalid32"}, 32'(rvalid_a), 32'(ev[0]));
    check({tag, "/rvalid20"}, 32'(rvalid_b), 32'(ev[1]));
    if (ek[0]) check({tag, "/rdata32"}, 32'(rdata_a), 32'(er[0]));
    if (ek[1]) check({tag, "/rdata20"}, 32'(rdata_b), 32'(er[1]));
  endtask

  task automatic cyc(input bit w, input int wa, input logic [15:0] wd,
                     input bit r, input int ra, input bit c, input string tag);
    wr = w; waddr = wa[4:0]; wdata = wd; rd = r; raddr = ra[4:0]; clr = c;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_outputs(tag);
    $display("%0t %s wr=%0b wa=%0d wd=%h rd=%0b ra=%0d clr=%0b | d32 v=%0b q=%h busy=%0b | d20 v=%0b q=%h busy=%0b",
             $time, tag, w, wa, wd, r, ra, c, rvalid_a, rdata_a, busy_a, rvalid_b, rdata_b, busy_b);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 0, 16'h0, 1'b0, 0, 1'b0, tag);
  endtask

  initial begin
    int nb_a, nb_b;
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0;
    waddr = '0; raddr = '0; wdata = '0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        kn[k][i] = 1'b0;
        mm[k][i] = '0;
      end
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic write then read, one-cycle rvalid pulse.
    cyc(1'b1, 3, 16'hA5A5, 1'b0, 0, 1'b0, "t1_wr");
    cyc(1'b0, 0, 16'h0, 1'b1, 3, 1'b0, "t1_rd");
    check("t1_rdata", 32'(rdata_a), 32'h0000A5A5);
    check("t1_rvalid", 32'(rvalid_a), 32'd1);
    idle("t1_pulse");

    // Write-first on same-address collision.
    cyc(1'b1, 7, 16'h1234, 1'b1, 7, 1'b0, "t2_wf");
    check("t2_rdata32", 32'(rdata_a), 32'h00001234);
    check("t2_rdata20", 32'(rdata_b), 32'h00001234);

    for (int i = 0; i < 32; i++) cyc(1'b1, i, 16'($urandom), 1'b0, 0, 1'b0, "fill");
    for (int i = 0; i < 32; i++) cyc(1'b0, 0, 16'h0, 1'b1, i, 1'b0, "fill_rd");

    // Out-of-range write/read on the 20-word instance.
    cyc(1'b1, 25, 16'hFFFF, 1'b0, 0, 1'b0, "t4_wr");
    cyc(1'b0, 0, 16'h0, 1'b1, 25, 1'b0, "t4_rd");
    check("t4_rdata20", 32'(rdata_b), 32'd0);
    check("t4_rvalid20", 32'(rvalid_b), 32'd1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 0, 16'h0, 1'b1, i, 1'b0, "t4_keep");

    // Clear with rd/wr traffic and a second clr while busy.
    cyc(1'b0, 0, 16'h0, 1'b0, 0, 1'b1, "t3_clr");
    nb_a = int'(busy_a); nb_b = int'(busy_b);
    for (int k = 0; k < 40; k++) begin
      if (k < 20)
        cyc(1'($urandom_range(0, 1)), $urandom_range(0, 31), 16'($urandom),
            1'($urandom_range(0, 1)), $urandom_range(0, 31), k == 5, "t3_busy");
      else
        idle("t3_tail");
      nb_a += int'(busy_a); nb_b += int'(busy_b);
    end
    check("t3_busy_len32", 32'(nb_a), 32'd32);
    check("t3_busy_len20", 32'(nb_b), 32'd20);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 0, 16'h0, 1'b1, i, 1'b0, "t3_rd0");
      check("t3_zero32", 32'(rdata_a), 32'd0);
    end

    // clr beats a same-cycle write; re-clr during CLEAR does not extend busy.
    cyc(1'b1, 2, 16'h7777, 1'b0, 0, 1'b0, "t5_pre");
    cyc(1'b1, 2, 16'h0055, 1'b0, 0, 1'b1, "t5_clr_wr");
    nb_a = int'(busy_a);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 0, 16'h0, 1'b0, 0, k == 3, "t5_busy");
      nb_a += int'(busy_a);
    end
    check("t5_busy_len32", 32'(nb_a), 32'd32);
    cyc(1'b0, 0, 16'h0, 1'b1, 2, 1'b0, "t5_rd2");
    check("t5_mem2", 32'(rdata_a), 32'd0);

    // Reset in the middle of a clear.
    for (int i = 0; i < 32; i++) cyc(1'b1, i, 16'($urandom_range(1, 16'hFFFF)), 1'b0, 0, 1'b0, "t6_fill");
    cyc(1'b0, 0, 16'h0, 1'b1, 15, 1'b0, "t6_rd");
    cyc(1'b0, 0, 16'h0, 1'b0, 0, 1'b1, "t6_clr");
    for (int k = 0; k < 10; k++) idle("t6_clearing");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_busy", 32'(busy_a), 32'd0);
    check("t6_async_rvalid", 32'(rvalid_a), 32'd0);
    check("t6_async_rdata", 32'(rdata_a), 32'd0);
    check_outputs("t6_async");
    @(posedge clk); #1;
    check_outputs("t6_held");
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) cyc(1'b0, 0, 16'h0, 1'b1, i, 1'b0, "t6_rd_after");

    // Random traffic with occasional clears.
    for (int k = 0; k < 400; k++)
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 31), 16'($urandom),
          1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 63) == 0, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
